// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result and flags.
//   One operation per transfer on the input valid/ready channel. ADD, SUB, AND,
//   OR and the three shifts complete on the accepting edge. MUL is an unsigned
//   shift-add that takes WIDTH cycles.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid / in_ready          input handshake (in_ready is combinational)
//   op[2:0], a, b                opcode and operands, captured on transfer
//   out_valid / out_ready        output handshake
//   result, zero, negative,
//   carry, overflow              registered result and flags
//   busy                         high while MUL iterates
`timescale 1ns/1ps
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_w, dif_w, shl_w, shr_w, sra_w;
  logic [PW-1:0]    acc_step;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             ld_en;
  logic [WIDTH-1:0] ld_res;
  logic             ld_c, ld_v;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[SHW-1:0];

  // Extra bit on each shift captures the last bit shifted out (0 when shamt==0).
  assign sum_w = {1'b0, a} + {1'b0, b};
  assign dif_w = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;
  assign sra_w = $signed({a, 1'b0}) >>> shamt;

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

  // Single-cycle datapath.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif_w[WIDTH-1:0];
        alu_c   = dif_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      OP_SRA: begin
        alu_res = sra_w[WIDTH:1];
        alu_c   = sra_w[0];
      end
      default: ;
    endcase
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    ld_en       = 1'b0;
    ld_res      = '0;
    ld_c        = 1'b0;
    ld_v        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
          end else begin
            ld_en  = 1'b1;
            ld_res = alu_res;
            ld_c   = alu_c;
            ld_v   = alu_v;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ld_en   = 1'b1;
          ld_res  = acc_step[WIDTH-1:0];
          ld_c    = |acc_step[PW-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase

    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    if (ld_en) begin
      out_valid_d = 1'b1;
      result_d    = ld_res;
      zero_d      = (ld_res == '0);
      negative_d  = ld_res[WIDTH-1];
      carry_d     = ld_c;
      overflow_d  = ld_v;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      negative_q  <= 1'b0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      negative_q  <= negative_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign negative  = negative_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=8) with hand-computed results.
// Flags are compared as the nibble {zero, negative, carry, overflow}.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int unsigned W = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] SHL = 3'b100;
  localparam logic [2:0] SHR = 3'b101;
  localparam logic [2:0] SRA = 3'b110;
  localparam logic [2:0] MUL = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, negative, carry, overflow, busy;
  logic [3:0]   flg;

  int n_vec = 0;
  int n_err = 0;

  assign flg = {zero, negative, carry, overflow};

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one single-cycle op with out_ready high; result must appear right after the edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic [3:0] ef);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, " result"}, 32'(result), 32'(er));
    check_eq({tag, " flags"}, 32'(flg), 32'(ef));
  endtask

  // Offer a MUL and check the exact WIDTH-cycle latency with busy/in_ready behaviour.
  task automatic run_mul(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic [3:0] ef);
    op = MUL; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    a = '0; b = '0;
    for (int i = 1; i < int'(W); i++) begin
      check_eq({tag, " busy/ov/rdy"}, 32'({busy, out_valid, in_ready}), 32'b100);
      tick();
    end
    check_eq({tag, " busy/ov/rdy last"}, 32'({busy, out_valid, in_ready}), 32'b100);
    tick();
    check_eq({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, " busy"}, 32'(busy), 32'd0);
    check_eq({tag, " result"}, 32'(result), 32'(er));
    check_eq({tag, " flags"}, 32'(flg), 32'(ef));
  endtask

  initial begin
    #2;
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst result", 32'(result), 32'd0);
    check_eq("rst flags", 32'(flg), 32'd0);
    check_eq("rst in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();

    // Arithmetic boundaries, back to back at one op per cycle.
    run_op("add 7f+01", ADD, 8'h7F, 8'h01, 8'h80, 4'b0101);
    run_op("add ff+01", ADD, 8'hFF, 8'h01, 8'h00, 4'b1010);
    run_op("sub 00-01", SUB, 8'h00, 8'h01, 8'hFF, 4'b0100);
    run_op("sub 05-05", SUB, 8'h05, 8'h05, 8'h00, 4'b1010);
    run_op("sub 80-01", SUB, 8'h80, 8'h01, 8'h7F, 4'b0011);
    run_op("and f0&3c", AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    run_op("shl 81<<1", SHL, 8'h81, 8'h01, 8'h02, 4'b0010);
    run_op("shr 81>>1", SHR, 8'h81, 8'h01, 8'h40, 4'b0010);
    run_op("sra 80>>>3", SRA, 8'h80, 8'h03, 8'hF0, 4'b0100);
    run_op("sra c1>>>1", SRA, 8'hC1, 8'h01, 8'hE0, 4'b0110);
    run_op("shl 5a s=0", SHL, 8'h5A, 8'h08, 8'h5A, 4'b0000);

    // Multiplier.
    run_mul("mul 10*10", 8'h10, 8'h10, 8'h00, 4'b1010);
    run_mul("mul 0f*0f", 8'h0F, 8'h0F, 8'hE1, 4'b0100);

    // Back-pressure: result frozen, then consume and accept on the same edge.
    run_op("add 01+02", ADD, 8'h01, 8'h02, 8'h03, 4'b0000);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp out_valid", 32'(out_valid), 32'd1);
      check_eq("bp result", 32'(result), 32'h03);
      check_eq("bp flags", 32'(flg), 32'd0);
      check_eq("bp in_ready", 32'(in_ready), 32'd0);
    end
    op = OR; a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
    #1;
    check_eq("bp queued in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check_eq("bp release in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp or out_valid", 32'(out_valid), 32'd1);
    check_eq("bp or result", 32'(result), 32'hFF);
    check_eq("bp or flags", 32'(flg), 32'b0100);

    // Reset during MUL iteration 4 abandons the operation.
    op = MUL; a = 8'h0F; b = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("mid-mul busy", 32'(busy), 32'd1);
    check_eq("mid-mul result held", 32'(result), 32'hFF);
    rst_n = 1'b0;
    #1;
    check_eq("rst2 out_valid", 32'(out_valid), 32'd0);
    check_eq("rst2 busy", 32'(busy), 32'd0);
    check_eq("rst2 result", 32'(result), 32'd0);
    check_eq("rst2 flags", 32'(flg), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("post-rst in_ready", 32'(in_ready), 32'd1);
    check_eq("post-rst out_valid", 32'(out_valid), 32'd0);
    run_op("add 02+03", ADD, 8'h02, 8'h03, 8'h05, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
